fpro_bus_arbiter: RTL

Shares the single FPro MMIO bus (the `mmio_*` interface into the MMIO controller and its 64 slots) between up to four bus masters, e.g. the MicroBlaze MCS plus a DMA or debug-UART master. Each master issues single read/write transactions through a req/ack handshake. The arbiter grants masters round-robin, with an optional bounded lock for back-to-back accesses. It drives one registered FPro cycle per transaction and returns registered read data. It sits between the masters and `MMIO_Controller`.

---
 rtl/fpro_arb_pkg.sv | 10 +
 rtl/fpro_bus_arbiter_rr_grant.sv | 50 +++++
 rtl/fpro_bus_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fpro_arb_pkg.sv
// Shared types and widths for the FPro MMIO bus arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   FPRO_ADDR_W  : FPro word-address width
//   FPRO_DATA_W  : FPro data width
package fpro_arb_pkg;
  localparam int FPRO_ADDR_W = 21;
  localparam int FPRO_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} arb_state_t;
endpackage

// File: rtl/fpro_bus_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker with an optional hold.
//   req      : per-master request vector
//   ptr      : index the upward scan starts from (wraps at NUM_MASTERS-1)
//   hold_en  : when set and req[hold_idx] is high, hold_idx wins outright
//   hold_idx : master to keep granted
//   grant    : one-hot winner (all zero when nothing requests)
//   gidx     : winner index
module rr_grant
  import fpro_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic                   hold_en,
  input  logic [IDX_W-1:0]       hold_idx,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       gidx
);

  logic           found;
  logic [IDX_W:0] sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (hold_en && req[hold_idx]) begin
      grant[hold_idx] = 1'b1;
      gidx            = hold_idx;
    end else begin
      // First requester at or after ptr, wrapping modulo NUM_MASTERS.
      for (int k = 0; k < NUM_MASTERS; k++) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_MASTERS)) sum = sum - (IDX_W+1)'(NUM_MASTERS);
        idx = sum[IDX_W-1:0];
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = idx;
        end
      end
    end
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: shares the FPro MMIO bus between NUM_MASTERS masters.
// One transaction takes IDLE -> ISSUE -> ACK (3 cycles). Round-robin with a
// bounded lock that lets a master keep the bus for up to MAX_LOCK extra grants.
//   clk, reset          : clock, synchronous active-high reset
//   m_req/m_write/m_lock: per-master request, direction, lock request
//   m_addr/m_wr_data    : per-master address and write data
//   m_ack               : one-cycle one-hot completion pulse
//   m_rd_data           : registered read data, updated on read completions
//   busy                : FSM not in IDLE
//   mmio_*              : FPro bus toward MMIO_Controller
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_LOCK    = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_MASTERS-1:0]                   m_req,
  input  logic [NUM_MASTERS-1:0]                   m_write,
  input  logic [NUM_MASTERS-1:0]                   m_lock,
  input  logic [NUM_MASTERS-1:0][FPRO_ADDR_W-1:0]  m_addr,
  input  logic [NUM_MASTERS-1:0][FPRO_DATA_W-1:0]  m_wr_data,
  output logic [NUM_MASTERS-1:0]                   m_ack,
  output logic [FPRO_DATA_W-1:0]                   m_rd_data,
  output logic                                     busy,
  output logic                                     mmio_cs,
  output logic                                     mmio_read,
  output logic                                     mmio_write,
  output logic [FPRO_ADDR_W-1:0]                   mmio_addr,
  output logic [FPRO_DATA_W-1:0]                   mmio_wr_data,
  input  logic [FPRO_DATA_W-1:0]                   mmio_rd_data
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr, g_idx;      // g_idx: current/previous winner
  logic                   prev_lock;          // m_lock of the previous winner at its grant
  logic [CNT_W-1:0]       lock_cnt;
  logic                   wr_lat;
  logic [FPRO_ADDR_W-1:0] addr_lat;
  logic [FPRO_DATA_W-1:0] data_lat;

  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       gidx, ptr_inc;
  logic                   hold_en, held, forced, lock_g, grant_go;

  // Once lock_cnt reaches MAX_LOCK the hold is withdrawn; rr_ptr already
  // sits at p+1 from p's original grant, so the plain scan visits p last.
  assign hold_en  = prev_lock && (lock_cnt < LOCK_MAX);
  assign held     = hold_en && m_req[g_idx];
  assign forced   = prev_lock && (lock_cnt == LOCK_MAX) && (gidx == g_idx);
  assign lock_g   = |(grant & m_lock);
  assign grant_go = (state == IDLE) && (|m_req);
  assign ptr_inc  = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  rr_grant #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_rr (
    .req      (m_req),
    .ptr      (rr_ptr),
    .hold_en  (hold_en),
    .hold_idx (g_idx),
    .grant    (grant),
    .gidx     (gidx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    m_ack        = '0;
    mmio_cs      = 1'b0;
    mmio_write   = 1'b0;
    mmio_read    = 1'b0;
    busy         = (state != IDLE);
    mmio_addr    = addr_lat;
    mmio_wr_data = data_lat;
    case (state)
      IDLE:  if (|m_req) state_nxt = ISSUE;
      ISSUE: begin
        mmio_cs    = 1'b1;
        mmio_write = wr_lat;
        mmio_read  = ~wr_lat;
        state_nxt  = ACK;
      end
      ACK: begin
        m_ack[g_idx] = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      g_idx     <= '0;
      prev_lock <= 1'b0;
      lock_cnt  <= '0;
      wr_lat    <= 1'b0;
      addr_lat  <= '0;
      data_lat  <= '0;
      m_rd_data <= '0;
    end else begin
      if (grant_go) begin
        wr_lat    <= m_write[gidx];
        addr_lat  <= m_addr[gidx];
        data_lat  <= m_wr_data[gidx];
        g_idx     <= gidx;
        prev_lock <= lock_g;
        rr_ptr    <= held ? rr_ptr : ptr_inc;
        if (!lock_g)     lock_cnt <= '0;
        else if (held)   lock_cnt <= lock_cnt + 1'b1;
        else if (forced) lock_cnt <= CNT_W'(1);  // sole requester after forced rotation
        else             lock_cnt <= '0;
      end
      if (state == ISSUE && !wr_lat) m_rd_data <= mmio_rd_data;
    end
  end

endmodule
